int_to_fp_seq: RTL
==================

# int_to_fp_seq

Sequential converter from a sign-magnitude integer to the team's short floating-point format: sign, 4-bit exponent, 8-bit normalized fraction, value = 0.frac × 2^exp. It normalizes with one left shift per cycle rather than a priority encoder. It sits directly upstream of the floating-point comparator and drives that block's sign/exp/frac operand inputs. Valid/ready handshakes are used on both sides.

## Interface
- INT_W, 12, magnitude width; legal range FRAC_W+1 ≤ INT_W ≤ 2^EXP_W − 2
- EXP_W, 4, exponent width
- FRAC_W, 8, fraction width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter idle and accepting
- sign_in  in  1  1 = negative
- mag_in  in  INT_W  unsigned magnitude
- out_valid  out  1  result valid; held until it is accepted
- out_ready  in  1  downstream accepts the result
- sign_out  out  1  result sign
- exp_out  out  EXP_W  result exponent
- frac_out  out  FRAC_W  result fraction; MSB is 1 unless the result is zero

## Operation
- FSM states: IDLE, NORM, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, load sign_in and mag_in into a working register, set the exponent counter to INT_W, and move to NORM.
- NORM (one decision per cycle):
  - Working register = 0: result is sign 0, exp 0, frac 0 (negative zero becomes +0). Move to DONE.
  - Working register MSB = 1: frac_out = reg[INT_W-1 -: FRAC_W], exp_out = counter, sign_out = latched sign. Move to DONE.
  - Otherwise: shift the register left by 1, decrement the counter, and stay in NORM.
- DONE:
  - out_valid=1. Outputs are stable.
  - When out_ready=1, move to IDLE. No new input is accepted in that same cycle.
- Truncation is the default; bits below the fraction are discarded.
- The exponent never underflows. A nonzero magnitude always terminates with counter ≥ 1.
- in_valid while in_ready=0 is ignored and no operand is captured. Upstream must hold the operand until the handshake.
- Reset (asynchronous) at any point aborts the conversion. All outputs go to 0 and in_ready returns to 1 once reset is deasserted.

## Timing
- Let lz = leading-zero count of mag_in, in the range 0..INT_W-1.
- Accept edge E0, where in_valid && in_ready.
- Nonzero input: out_valid rises after edge E0+1+lz.
- Zero input: out_valid rises after edge E0+1.
- Worst case is mag=1: out_valid after E0+INT_W.
- With rounding enabled, the same latencies apply; rounding is folded into the final NORM cycle.
- in_ready falls after E0 and rises after the out_valid && out_ready edge.
- Minimum issue interval is latency + 2 cycles.
- Reset values: in_ready=1, out_valid=0, sign_out=0, exp_out=0, frac_out=0.
- Outputs are registered, with no combinational path from in_* to out_*.
- out_ready is sampled only in DONE.

## Configuration
- INT_TO_FP_ROUND_EN defined: round-half-up using the guard bit reg[INT_W-1-FRAC_W].
  - If the fraction is all ones and rounds up, frac=1000_0000 and exp=counter+1. The legal INT_W range guarantees no exponent overflow.
- Not defined: pure truncation. Guard-bit logic is absent.

## Structure
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, INT_W
  - the state enum {IDLE, NORM, DONE}
  - the zero-result constant, shared with the comparator
- One sub-module, fp_round_unit (combinational frac/exp increment with renormalize), instantiated only under INT_TO_FP_ROUND_EN. Everything else stays in int_to_fp_seq.

## Test plan
- sign=0, mag=0x800 → sign 0, exp 12, frac 0x80; out_valid one cycle after accept.
- sign=0, mag=0x001 → exp 1, frac 0x80; out_valid 12 cycles after accept.
- sign=1, mag=0x0FF → sign 1, exp 8, frac 0xFF, 5 cycles.
- sign=1, mag=0x000 → sign 0, exp 0, frac 0x00, 1 cycle.
- mag=0xFF8, hold out_ready=0 for 5 cycles:
  - outputs stay stable throughout and in_ready stays 0.
  - macro off → exp 12, frac 0xFF.
  - macro on → exp 13, frac 0x80.
- Assert reset_n=0 mid-NORM for mag=0x010:
  - out_valid, exp_out and frac_out are 0 immediately.
  - in_ready=1 after release.
  - a following mag=0x010 gives exp 5, frac 0x80.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM state encoding and zero result for the short float format.
package fp_pkg;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;
    localparam int INT_W  = 12;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    localparam fp_t FP_ZERO = '0;
endpackage

// File: rtl/fp_round_unit.sv
// fp_round_unit: round-half-up of a truncated fraction with renormalize on carry-out.
// Only built with INT_TO_FP_ROUND_EN defined; truncation builds carry no guard-bit logic.
`ifdef INT_TO_FP_ROUND_EN
module fp_round_unit
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] frac_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              guard,
    output logic [FRAC_W-1:0] frac_out,
    output logic [EXP_W-1:0]  exp_out
);
    logic [FRAC_W:0] sum;
    assign sum      = {1'b0, frac_in} + {{FRAC_W{1'b0}}, guard};
    // carry-out means the fraction was all ones: renormalize to 0.1000_0000 and bump exponent
    assign frac_out = sum[FRAC_W] ? {1'b1, {(FRAC_W-1){1'b0}}} : sum[FRAC_W-1:0];
    assign exp_out  = exp_in + {{(EXP_W-1){1'b0}}, sum[FRAC_W]};
endmodule
`endif

// File: rtl/int_to_fp_seq.sv
// int_to_fp_seq: sign-magnitude integer to short float, normalizing one left shift per cycle.
// Define INT_TO_FP_ROUND_EN for round-half-up on the guard bit; default is truncation.
module int_to_fp_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [INT_W-1:0]  mag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out
);
    state_t            state, state_nxt;
    logic [INT_W-1:0]  work, work_nxt;
    logic [EXP_W-1:0]  cnt, cnt_nxt;
    logic              sign_r, sign_nxt;
    fp_t               res, res_nxt;
    logic [FRAC_W-1:0] frac_t;
    logic [EXP_W-1:0]  exp_t;

`ifdef INT_TO_FP_ROUND_EN
    fp_round_unit u_round (
        .frac_in  (work[INT_W-1 -: FRAC_W]),
        .exp_in   (cnt),
        .guard    (work[INT_W-1-FRAC_W]),
        .frac_out (frac_t),
        .exp_out  (exp_t)
    );
`else
    assign frac_t = work[INT_W-1 -: FRAC_W];
    assign exp_t  = cnt;
`endif

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        sign_nxt  = sign_r;
        res_nxt   = res;
        case (state)
            IDLE: if (in_valid) begin
                work_nxt  = mag_in;
                sign_nxt  = sign_in;
                cnt_nxt   = EXP_W'(INT_W);
                state_nxt = NORM;
            end
            NORM: if (work == '0) begin
                // negative zero collapses to +0
                res_nxt   = FP_ZERO;
                state_nxt = DONE;
            end else if (work[INT_W-1]) begin
                res_nxt   = {sign_r, exp_t, frac_t};
                state_nxt = DONE;
            end else begin
                work_nxt  = work << 1;
                cnt_nxt   = cnt - 1'b1;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            sign_r <= 1'b0;
            res    <= FP_ZERO;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            cnt    <= cnt_nxt;
            sign_r <= sign_nxt;
            res    <= res_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sign_out  = res.sign;
    assign exp_out   = res.exp;
    assign frac_out  = res.frac;
endmodule
